// File: rtl/burst_sequencer_if.sv
// Stream bundle for burst_sequencer: sample intake handshake, replay request,
// and the go / data / finish replay stream towards the rangefinder.
interface burst_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             in_ready;
   logic             replay;
   logic             go;
   logic [WIDTH-1:0] data_out;
   logic             finish;
   logic             trunc;
   logic             busy;

   modport slave (
      input  in_valid, in_data, in_last, replay,
      output in_ready, go, data_out, finish, trunc, busy
   );

   modport master (
      output in_valid, in_data, in_last, replay,
      input  in_ready, go, data_out, finish, trunc, busy
   );
endinterface

// File: rtl/burst_sequencer.sv
// Buffers a burst of up to DEPTH samples, then replays it gap-free as go / data / finish.
// Optional macro BURST_SEQ_REPLAY_EN adds re-streaming of the previous burst on request.
module burst_sequencer #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic              clock,
   input  logic              reset,
   burst_sequencer_if.slave  bus
);
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_PLAY    = 2'd2,
      S_FIN     = 2'd3
   } state_t;

   state_t            r_state, w_state_next;
   logic [CNT_W-1:0]  r_wr_cnt, w_wr_cnt_next, w_wr_cnt_inc;
   logic [CNT_W-1:0]  r_burst_len, w_burst_len_next;
   logic [ADDR_W-1:0] r_rd_idx, w_rd_idx_next, w_rd_addr, w_wr_addr;
   logic              r_trunc, w_trunc_next;
   logic [WIDTH-1:0]  r_buf [DEPTH];
   logic [WIDTH-1:0]  r_data_out;
   logic              w_in_ready, w_accept, w_close_full, w_bypass;
   logic              w_replay_start, w_replay_trunc;

`ifdef BURST_SEQ_REPLAY_EN
   logic r_replay_ok;
   logic r_trunc_hist;

   assign w_replay_start = (r_state == S_IDLE) && bus.replay && r_replay_ok;
   assign w_replay_trunc = r_trunc_hist;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_replay_ok  <= 1'b0;
         r_trunc_hist <= 1'b0;
      end else begin
         if (r_state == S_FIN)
            r_replay_ok <= 1'b1;
         if (w_accept && (w_state_next == S_PLAY))
            r_trunc_hist <= w_trunc_next;
      end
   end
`else
   logic w_unused_replay;

   assign w_unused_replay = bus.replay;
   assign w_replay_start  = 1'b0;
   assign w_replay_trunc  = 1'b0;
`endif

   assign w_in_ready   = ((r_state == S_IDLE) || (r_state == S_COLLECT)) && !w_replay_start;
   assign w_accept     = bus.in_valid && w_in_ready;
   assign w_wr_cnt_inc = r_wr_cnt + CNT_W'(1);
   assign w_close_full = (w_wr_cnt_inc == CNT_W'(DEPTH));
   assign w_wr_addr    = r_wr_cnt[ADDR_W-1:0];

   always_comb begin
      w_state_next     = r_state;
      w_wr_cnt_next    = r_wr_cnt;
      w_burst_len_next = r_burst_len;
      w_rd_idx_next    = r_rd_idx;
      w_trunc_next     = r_trunc;
      case (r_state)
         S_IDLE, S_COLLECT: begin
            w_rd_idx_next = '0;
            if (w_replay_start) begin
               w_state_next = S_PLAY;
               w_trunc_next = w_replay_trunc;
            end else if (w_accept) begin
               w_wr_cnt_next = w_wr_cnt_inc;
               if (bus.in_last || w_close_full) begin
                  w_state_next     = S_PLAY;
                  w_burst_len_next = w_wr_cnt_inc;
                  // A last flag on the DEPTH-th sample is a normal close.
                  w_trunc_next     = !bus.in_last;
               end else begin
                  w_state_next = S_COLLECT;
               end
            end
         end
         S_PLAY: begin
            w_rd_idx_next = r_rd_idx + ADDR_W'(1);
            if (CNT_W'(r_rd_idx) == (r_burst_len - CNT_W'(1)))
               w_state_next = S_FIN;
         end
         S_FIN: begin
            w_state_next  = S_IDLE;
            w_wr_cnt_next = '0;
            w_trunc_next  = 1'b0;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_wr_cnt    <= '0;
         r_burst_len <= '0;
         r_rd_idx    <= '0;
         r_trunc     <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_wr_cnt    <= w_wr_cnt_next;
         r_burst_len <= w_burst_len_next;
         r_rd_idx    <= w_rd_idx_next;
         r_trunc     <= w_trunc_next;
      end
   end

   always_ff @(posedge clock) begin
      if (w_accept)
         r_buf[w_wr_addr] <= bus.in_data;
   end

   // Read one cycle ahead so data_out is registered; a single-sample burst
   // reads the word being written in the same cycle, hence the bypass.
   assign w_rd_addr = (r_state == S_PLAY) ? (r_rd_idx + ADDR_W'(1)) : '0;
   assign w_bypass  = w_accept && (w_wr_addr == w_rd_addr);

   always_ff @(posedge clock) begin
      if (reset)
         r_data_out <= '0;
      else if (w_state_next == S_PLAY)
         r_data_out <= w_bypass ? bus.in_data : r_buf[w_rd_addr];
      else
         r_data_out <= '0;
   end

   assign bus.in_ready = w_in_ready;
   assign bus.go       = (r_state == S_PLAY) && (r_rd_idx == '0);
   assign bus.data_out = r_data_out;
   assign bus.finish   = (r_state == S_FIN);
   assign bus.trunc    = r_trunc;
   assign bus.busy     = (r_state == S_PLAY) || (r_state == S_FIN);
endmodule

// File: tb/tb_burst_sequencer.sv
// Directed bench for burst_sequencer: normal, truncated, single-sample,
// reset-abort and replay bursts with hand-computed expected streams.
module tb_burst_sequencer;
   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   burst_sequencer_if #(.WIDTH(16)) u_bus ();

   burst_sequencer #(
      .WIDTH (16),
      .DEPTH (16)
   ) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (u_bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic go, input logic [15:0] data,
                             input logic fin, input logic trunc, input logic busy,
                             input logic rdy);
      check_value({tag, ".go"},       u_bus.go,       go);
      check_value({tag, ".data"},     u_bus.data_out, data);
      check_value({tag, ".finish"},   u_bus.finish,   fin);
      check_value({tag, ".trunc"},    u_bus.trunc,    trunc);
      check_value({tag, ".busy"},     u_bus.busy,     busy);
      check_value({tag, ".in_ready"}, u_bus.in_ready, rdy);
   endtask

   task automatic send(input string tag, input logic [15:0] data, input logic last);
      u_bus.in_valid = 1'b1;
      u_bus.in_data  = data;
      u_bus.in_last  = last;
      check_value({tag, ".ready"}, u_bus.in_ready, 1'b1);
      step();
      u_bus.in_valid = 1'b0;
      u_bus.in_last  = 1'b0;
      $display("accept %s data=0x%04h last=%0d", tag, data, last);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset          = 1'b1;
      u_bus.in_valid = 1'b0;
      u_bus.in_data  = '0;
      u_bus.in_last  = 1'b0;
      u_bus.replay   = 1'b0;
      step();
      step();
      reset = 1'b0;
      expect_out("rst", 0, 16'h0000, 0, 0, 0, 1);

      // Three samples with gaps, last on the third.
      send("t1.a", 16'h0005, 0);
      step();
      send("t1.b", 16'h0012, 0);
      step();
      send("t1.c", 16'h0009, 1);
      expect_out("t1.s0",  1, 16'h0005, 0, 0, 1, 0);
      step();
      expect_out("t1.s1",  0, 16'h0012, 0, 0, 1, 0);
      step();
      expect_out("t1.s2",  0, 16'h0009, 0, 0, 1, 0);
      step();
      expect_out("t1.fin", 0, 16'h0000, 1, 0, 1, 0);
      step();
      expect_out("t1.idl", 0, 16'h0000, 0, 0, 0, 1);
      $display("burst t1 streamed");

      // Sixteen back-to-back samples fill the buffer; 0x0011 is then held upstream.
      u_bus.in_valid = 1'b1;
      u_bus.in_last  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         u_bus.in_data = 16'(i + 1);
         step();
      end
      u_bus.in_data = 16'h0011;
      for (int k = 0; k < 16; k++) begin
         expect_out($sformatf("t2.s%0d", k), (k == 0), 16'(k + 1), 0, 1, 1, 0);
         step();
      end
      expect_out("t2.fin", 0, 16'h0000, 1, 1, 1, 0);
      step();
      expect_out("t2.idl", 0, 16'h0000, 0, 0, 0, 1);
      step();
      u_bus.in_data = 16'h0012;
      step();
      u_bus.in_data = 16'h0013;
      step();
      u_bus.in_data = 16'h0014;
      u_bus.in_last = 1'b1;
      step();
      u_bus.in_valid = 1'b0;
      u_bus.in_last  = 1'b0;
      expect_out("t2b.s0",  1, 16'h0011, 0, 0, 1, 0);
      step();
      expect_out("t2b.s1",  0, 16'h0012, 0, 0, 1, 0);
      step();
      expect_out("t2b.s2",  0, 16'h0013, 0, 0, 1, 0);
      step();
      expect_out("t2b.s3",  0, 16'h0014, 0, 0, 1, 0);
      step();
      expect_out("t2b.fin", 0, 16'h0000, 1, 0, 1, 0);
      step();
      expect_out("t2b.idl", 0, 16'h0000, 0, 0, 0, 1);
      $display("burst t2 streamed");

      // Single-sample burst.
      send("t3", 16'h00AB, 1);
      expect_out("t3.s0",  1, 16'h00AB, 0, 0, 1, 0);
      step();
      expect_out("t3.fin", 0, 16'h0000, 1, 0, 1, 0);
      step();
      expect_out("t3.idl", 0, 16'h0000, 0, 0, 0, 1);
      $display("burst t3 streamed");

      // Reset on the second PLAY cycle of a 5-sample burst.
      u_bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         u_bus.in_data = 16'(16'h0021 + i);
         u_bus.in_last = (i == 4);
         step();
      end
      u_bus.in_valid = 1'b0;
      u_bus.in_last  = 1'b0;
      expect_out("t4.s0", 1, 16'h0021, 0, 0, 1, 0);
      step();
      expect_out("t4.s1", 0, 16'h0022, 0, 0, 1, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      expect_out("t4.rst", 0, 16'h0000, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         check_value($sformatf("t4.nofin%0d", i), u_bus.finish, 1'b0);
      end
      send("t4.a", 16'h0031, 0);
      send("t4.b", 16'h0032, 1);
      expect_out("t4b.s0",  1, 16'h0031, 0, 0, 1, 0);
      step();
      expect_out("t4b.s1",  0, 16'h0032, 0, 0, 1, 0);
      step();
      expect_out("t4b.fin", 0, 16'h0000, 1, 0, 1, 0);
      step();
      expect_out("t4b.idl", 0, 16'h0000, 0, 0, 0, 1);
      $display("burst t4 streamed after abort");

      // Replay request together with a new sample in IDLE.
      send("t5.a", 16'h0007, 0);
      send("t5.b", 16'h0003, 1);
      expect_out("t5.s0",  1, 16'h0007, 0, 0, 1, 0);
      step();
      expect_out("t5.s1",  0, 16'h0003, 0, 0, 1, 0);
      step();
      expect_out("t5.fin", 0, 16'h0000, 1, 0, 1, 0);
      step();
      expect_out("t5.idl", 0, 16'h0000, 0, 0, 0, 1);
      u_bus.replay   = 1'b1;
      u_bus.in_valid = 1'b1;
      u_bus.in_data  = 16'h0055;
      u_bus.in_last  = 1'b1;
`ifdef BURST_SEQ_REPLAY_EN
      check_value("t5.rdy_replay", u_bus.in_ready, 1'b0);
      step();
      u_bus.replay = 1'b0;
      expect_out("t5r.s0",  1, 16'h0007, 0, 0, 1, 0);
      step();
      expect_out("t5r.s1",  0, 16'h0003, 0, 0, 1, 0);
      step();
      expect_out("t5r.fin", 0, 16'h0000, 1, 0, 1, 0);
      step();
      expect_out("t5r.idl", 0, 16'h0000, 0, 0, 0, 1);
      step();
      u_bus.in_valid = 1'b0;
      u_bus.in_last  = 1'b0;
      $display("replay of t5 streamed");
`else
      check_value("t5.rdy_replay", u_bus.in_ready, 1'b1);
      step();
      u_bus.replay   = 1'b0;
      u_bus.in_valid = 1'b0;
      u_bus.in_last  = 1'b0;
`endif
      expect_out("t5n.s0",  1, 16'h0055, 0, 0, 1, 0);
      step();
      expect_out("t5n.fin", 0, 16'h0000, 1, 0, 1, 0);
      step();
      expect_out("t5n.idl", 0, 16'h0000, 0, 0, 0, 1);
      $display("burst t5n streamed");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/burst_sequencer.md
# burst_sequencer

Upstream feeder for the rangefinder stage. Accepts samples one at a time with a valid/ready handshake at whatever rate the chip pins supply them, buffers a burst of up to DEPTH samples, then replays the burst as a gap-free stream. The replay uses the rangefinder's go / data / finish protocol: go with the first sample, one sample per clock, finish after the last. Its outputs connect directly to the rangefinder's go, finish and data_in inputs.

## Interface
- WIDTH, 16: sample width in bits.
- DEPTH, 16: burst buffer capacity in samples (≥2).

- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is a valid sample this cycle.
- in_data  input  WIDTH  sample value.
- in_last  input  1  qualifies in_valid; this sample closes the burst.
- in_ready  output  1  block accepts a sample this cycle.
- replay  input  1  request re-play of the previous burst (feature-gated, see Configuration).
- go  output  1  one-cycle pulse; data_out carries sample 0.
- data_out  output  WIDTH  replayed sample; 0 outside PLAY.
- finish  output  1  one-cycle pulse, the cycle after the last sample.
- trunc  output  1  high throughout PLAY and FIN of a burst closed by a full buffer.
- busy  output  1  high in PLAY and FIN.

## Operation
- States:
  - IDLE: empty.
  - COLLECT: at least one sample stored.
  - PLAY: streaming out.
  - FIN: finish cycle.
- Accept: in_valid && in_ready. The sample is written to buf[wr_cnt] and wr_cnt increments. wr_cnt is clog2(DEPTH+1) bits wide.
- in_ready = 1 in IDLE and COLLECT, 0 in PLAY and FIN. Samples offered in PLAY or FIN are neither consumed nor lost; the upstream source holds them.
- IDLE → COLLECT on an accept without in_last.
- IDLE or COLLECT → PLAY on an accept with in_last, or on the accept that makes wr_cnt == DEPTH.
  - If the burst closes by full buffer without in_last, latch trunc = 1.
  - in_last arriving on the DEPTH-th sample counts as a normal close: trunc = 0.
- PLAY: rd_idx starts at 0 and increments every cycle. data_out = buf[rd_idx]. go = (rd_idx == 0). When rd_idx == burst_len−1, the next state is FIN.
- FIN: finish = 1, data_out = 0. Next state is IDLE; wr_cnt clears and trunc clears.
- No back-pressure from downstream: PLAY never stalls.
- Buffer contents are never cleared. burst_len holds the length of the last burst.

## Timing
- Reset values: in_ready=1 (after the reset cycle), go=0, finish=0, data_out=0, trunc=0, busy=0. State = IDLE, wr_cnt=0, and the replay-valid flag is cleared.
- Reset asserted in any state aborts the current operation. No finish is emitted for an aborted burst.
- For a closing accept at cycle t with burst length N:
  - go and sample 0 at t+1.
  - Sample k at t+1+k.
  - finish at t+N+1.
  - in_ready high again at t+N+2.
- Single-sample burst: go at t+1, finish at t+2.
- go and finish are never high in the same cycle. go occurs exactly once per burst.
- All outputs are registered or decoded from registered state. There is no combinational path from in_* to outputs other than in_ready, which is a function of state only.

## Configuration
- Macro: BURST_SEQ_REPLAY_EN.
- Defined:
  - replay sampled high in IDLE, after at least one completed burst, enters PLAY next cycle.
  - It re-streams the stored burst with identical timing and the original trunc value.
  - If replay and in_valid are both high in IDLE, replay wins and in_ready is 0 that cycle.
  - replay is ignored in all other states.
- Undefined:
  - The replay input is ignored. in_ready depends on state only.
  - No replay-valid or trunc-history state is synthesized.

## Test plan
- Reset, then 3 samples 0x0005, 0x0012, 0x0009 (last on third) with 1-cycle gaps → go+0x0005 the cycle after the last accept, then 0x0012, 0x0009 on consecutive cycles, finish the next cycle, trunc=0.
- 20 samples 0x0001..0x0014, in_last never asserted, DEPTH=16 → in_ready drops after the 16th. Stream 0x0001..0x0010 with trunc=1. Sample 0x0011 is held upstream and accepted as the first sample of the next burst after finish.
- Single sample 0x00AB with in_last → go at t+1 with data_out=0x00AB, finish at t+2, in_ready=1 at t+3.
- Reset pulsed on the 2nd PLAY cycle of a 5-sample burst → all outputs 0 next cycle, no finish, the next burst starts cleanly from wr_cnt=0.
- BURST_SEQ_REPLAY_EN defined: after burst 0x0007, 0x0003, pulse replay together with in_valid in IDLE → identical go / 0x0007 / 0x0003 / finish sequence, and the in_valid sample is not consumed. Macro undefined: the same stimulus → replay is ignored and the sample is accepted.
